// File: rtl/counter_sequencer.sv
// counter_sequencer: start/stop/pause controlled up-counter that runs from 0
// to a limit captured at start. At the limit it either finishes (one-shot) or
// wraps to 0 and keeps running (auto-reload), pulsing done for one cycle.
// Optional tick prescaler: define COUNTER_SEQUENCER_PRESCALE_EN so that the
// count advances only every PRESCALE-th RUN cycle. Without the macro every
// RUN cycle is a tick.
//
// state | meaning
// IDLE  | stopped, count cleared, waiting for start
// RUN   | counting toward the captured limit
// HOLD  | paused, count and prescaler frozen
// DONE  | one-shot run finished, count holds the limit
module counter_sequencer #(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  if (PRESCALE < 2 || PRESCALE > 16) begin : g_prescale_range
    $error("counter_sequencer: PRESCALE must be within 2..16");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             rel_q, rel_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             adv;
  logic             clr;
  logic             tick;

  // A RUN cycle advances the timebase only when no higher-priority control is active
  always_comb begin
    clr = stop | start;
    adv = (state_q == ST_RUN) && !stop && !start && !pause;
  end

`ifdef COUNTER_SEQUENCER_PRESCALE_EN
  localparam int PSC_W = $clog2(PRESCALE);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc_q, psc_d;

  // Prescaler: counts advancing RUN cycles, ticks on the last one and wraps
  always_comb begin
    psc_d = psc_q;
    tick  = 1'b0;
    if (clr) begin
      psc_d = '0;
    end else if (adv) begin
      if (psc_q == PSC_LAST) begin
        psc_d = '0;
        tick  = 1'b1;
      end else begin
        psc_d = psc_q + PSC_W'(1);
      end
    end
  end

  // Prescaler register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end
`else
  // No prescaler: every advancing RUN cycle is a tick
  always_comb begin
    tick = adv;
  end
`endif

  // Next-state and registered-output logic; stop beats start beats pause beats tick
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lim_d   = lim_q;
    rel_d   = rel_q;
    done_d  = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (start) begin
      state_d = ST_RUN;
      count_d = '0;
      lim_d   = limit;
      rel_d   = reload;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_HOLD;
          end else if (tick) begin
            if (count_q == lim_q) begin
              done_d = 1'b1;
              if (rel_q) begin
                count_d = '0;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        ST_HOLD: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      lim_q   <= '0;
      rel_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      rel_q   <= rel_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer (WIDTH=3, PRESCALE=4).
// Observed vector is {state, count, busy, done}, sampled on the falling edge.
module tb_counter_sequencer;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       pause;
  logic       reload;
  logic [2:0] limit;
  logic [2:0] count;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int n_checks;
  int n_errors;

  counter_sequencer #(
    .WIDTH   (3),
    .PRESCALE(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .pause (pause),
    .reload(reload),
    .limit (limit),
    .count (count),
    .busy  (busy),
    .done  (done),
    .state (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; reload = 1'b0; limit = 3'd0;
    @(negedge clk);
    @(negedge clk);
    exp = {S_IDLE, 3'd0, 1'b0, 1'b0};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL reset_asserted: got %b expected %b", {state, count, busy, done}, exp);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++;
      if ({state, count, busy, done} !== exp) begin
        n_errors++;
        $display("FAIL reset_idle[%0d]: got %b expected %b", i, {state, count, busy, done}, exp);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [6:0] exp;
    start = 1'b1; limit = 3'd5; reload = 1'b0;
    cyc();
    start = 1'b0; limit = 3'd2; reload = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) cyc();
      exp = {S_RUN, 3'(k), 1'b1, 1'b0};
      n_checks++;
      if ({state, count, busy, done} !== exp) begin
        n_errors++;
        $display("FAIL one_shot_count[%0d]: got %b expected %b", k, {state, count, busy, done}, exp);
      end
    end
    cyc();
    exp = {S_DONE, 3'd5, 1'b0, 1'b1};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL one_shot_done: got %b expected %b", {state, count, busy, done}, exp);
    end
    exp = {S_DONE, 3'd5, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if ({state, count, busy, done} !== exp) begin
        n_errors++;
        $display("FAIL one_shot_hold[%0d]: got %b expected %b", i, {state, count, busy, done}, exp);
      end
    end
  endtask

  task automatic test_reload();
    logic [6:0] exp;
    start = 1'b1; limit = 3'd2; reload = 1'b1;
    cyc();
    start = 1'b0; limit = 3'd6; reload = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) cyc();
      exp = {S_RUN, 3'(k % 3), 1'b1, (k > 0) && (k % 3 == 0)};
      n_checks++;
      if ({state, count, busy, done} !== exp) begin
        n_errors++;
        $display("FAIL reload[%0d]: got %b expected %b", k, {state, count, busy, done}, exp);
      end
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    exp = {S_IDLE, 3'd0, 1'b0, 1'b0};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL reload_stop: got %b expected %b", {state, count, busy, done}, exp);
    end
  endtask

  task automatic test_pause();
    logic [6:0] exp;
    pause = 1'b1;
    cyc();
    exp = {S_IDLE, 3'd0, 1'b0, 1'b0};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL pause_in_idle: got %b expected %b", {state, count, busy, done}, exp);
    end
    pause = 1'b0;
    start = 1'b1; limit = 3'd7; reload = 1'b0;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) cyc();
    exp = {S_RUN, 3'd3, 1'b1, 1'b0};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL pause_pre: got %b expected %b", {state, count, busy, done}, exp);
    end
    pause = 1'b1;
    exp = {S_HOLD, 3'd3, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++;
      if ({state, count, busy, done} !== exp) begin
        n_errors++;
        $display("FAIL pause_hold[%0d]: got %b expected %b", i, {state, count, busy, done}, exp);
      end
    end
    pause = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      cyc();
      exp = {S_RUN, 3'(k), 1'b1, 1'b0};
      n_checks++;
      if ({state, count, busy, done} !== exp) begin
        n_errors++;
        $display("FAIL pause_resume[%0d]: got %b expected %b", k, {state, count, busy, done}, exp);
      end
    end
    cyc();
    exp = {S_DONE, 3'd7, 1'b0, 1'b1};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL pause_done: got %b expected %b", {state, count, busy, done}, exp);
    end
    cyc();
    exp = {S_DONE, 3'd7, 1'b0, 1'b0};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL pause_single_done: got %b expected %b", {state, count, busy, done}, exp);
    end
  endtask

  task automatic test_start_stop();
    logic [6:0] exp;
    start = 1'b1; limit = 3'd7; reload = 1'b0;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) cyc();
    exp = {S_RUN, 3'd4, 1'b1, 1'b0};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL start_stop_pre: got %b expected %b", {state, count, busy, done}, exp);
    end
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    exp = {S_IDLE, 3'd0, 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      if (i > 0) cyc();
      n_checks++;
      if ({state, count, busy, done} !== exp) begin
        n_errors++;
        $display("FAIL start_stop_idle[%0d]: got %b expected %b", i, {state, count, busy, done}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp;
    start = 1'b1; limit = 3'd6; reload = 1'b0;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) cyc();
    start = 1'b1; limit = 3'd1;
    cyc();
    start = 1'b0; limit = 3'd6;
    exp = {S_RUN, 3'd0, 1'b1, 1'b0};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL restart_clear: got %b expected %b", {state, count, busy, done}, exp);
    end
    cyc();
    exp = {S_RUN, 3'd1, 1'b1, 1'b0};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL restart_count: got %b expected %b", {state, count, busy, done}, exp);
    end
    cyc();
    exp = {S_DONE, 3'd1, 1'b0, 1'b1};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL restart_done: got %b expected %b", {state, count, busy, done}, exp);
    end
  endtask

  task automatic test_limit_zero();
    logic [6:0] exp;
    start = 1'b1; limit = 3'd0; reload = 1'b0;
    cyc();
    start = 1'b0;
    exp = {S_RUN, 3'd0, 1'b1, 1'b0};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL limit0_run: got %b expected %b", {state, count, busy, done}, exp);
    end
    cyc();
    exp = {S_DONE, 3'd0, 1'b0, 1'b1};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL limit0_done: got %b expected %b", {state, count, busy, done}, exp);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    exp = {S_IDLE, 3'd0, 1'b0, 1'b0};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL limit0_stop: got %b expected %b", {state, count, busy, done}, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] exp;
    start = 1'b1; limit = 3'd7; reload = 1'b0;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) cyc();
    exp = {S_RUN, 3'd3, 1'b1, 1'b0};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL async_pre: got %b expected %b", {state, count, busy, done}, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    exp = {S_IDLE, 3'd0, 1'b0, 1'b0};
    n_checks++;
    if ({state, count, busy, done} !== exp) begin
      n_errors++;
      $display("FAIL async_immediate: got %b expected %b", {state, count, busy, done}, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      n_checks++;
      if ({state, count, busy, done} !== exp) begin
        n_errors++;
        $display("FAIL async_after[%0d]: got %b expected %b", i, {state, count, busy, done}, exp);
      end
    end
  endtask

`ifdef COUNTER_SEQUENCER_PRESCALE_EN
  task automatic test_prescale();
    logic [6:0] exp;
    start = 1'b1; limit = 3'd1; reload = 1'b0;
    cyc();
    start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) cyc();
      if (k == 8) exp = {S_DONE, 3'd1, 1'b0, 1'b1};
      else        exp = {S_RUN, (k >= 4) ? 3'd1 : 3'd0, 1'b1, 1'b0};
      n_checks++;
      if ({state, count, busy, done} !== exp) begin
        n_errors++;
        $display("FAIL prescale[%0d]: got %b expected %b", k, {state, count, busy, done}, exp);
      end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
    test_prescale();
`else
    test_one_shot();
    test_reload();
    test_pause();
    test_start_stop();
    test_back_to_back();
    test_limit_zero();
    test_async_reset();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
